mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-port memory bus between the instruction-fetch port and the data port (MemControl NEWBUS side).
//  Both requesters use the early-strobe protocol: the strobe comes one cycle ahead; Stall is held until the access completes.
//  Sits between the CPU memory ports and the SRAM/bridge; grants, sequences, enforces fairness and a watchdog.
// PARAMETERS
//  D_STREAK_MAX  4    max consecutive data grants while an I request waits (1..15)
//  TIMEOUT       255  cycles a granted access may wait for mem_ready before forced completion (1..1023)
// PORTS
//  clock           in   1   single clock
//  reset_n         in   1   asynchronous, active-low reset
//  i_early_strobe  in   1   fetch access enters the M-equivalent slot next cycle
//  i_address       in   32  fetch address, stable while i_stall=1
//  i_stall         out  1   fetch access pending, not yet complete
//  i_read_data     out  32  mem_rdata; valid when the I access completes
//  d_early_strobe  in   1   data access enters the M stage next cycle
//  d_early_write   in   1   qualifies d_early_strobe as a write
//  d_address       in   32  data address, stable while d_stall=1
//  d_write_data    in   32  data to write
//  d_byte_select   in   4   byte lanes for writes
//  d_stall         out  1   data access pending, not yet complete
//  d_read_data     out  32  mem_rdata; valid when the D access completes
//  mem_req         out  1   access in progress; held until mem_ready
//  mem_addr        out  32  granted port address
//  mem_write       out  1   1 = write (D grant only)
//  mem_be          out  4   d_byte_select on write D grant, 4'b0000 otherwise
//  mem_wdata       out  32  d_write_data
//  mem_ready       in   1   access complete this cycle; mem_rdata valid
//  mem_rdata       in   32  read data
//  bus_error       out  1   one-cycle pulse on watchdog expiry
//  bus_error_seen  out  1   sticky bus_error; cleared only by reset
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, pend_i=pend_d=0, streak=0, wdog=0, bus_error_seen=0. All outputs 0, any open access abandoned.
//  - pend_x set on rising clock after x_early_strobe. Cleared on the clock where x completes; set wins if a strobe coincides with completion.
//  - d_early_write is latched with pend_d (wr_d).
//  - done = mem_req & (mem_ready | wdog==TIMEOUT).
//  - x_stall = pend_x & ~(grant==x & done). Combinational, so zero-wait memory gives no stall.
//  - FSM states IDLE, SERVE_I, SERVE_D. mem_req = (state!=IDLE). mem_addr/mem_write/mem_be are muxed by state.
//  - Next grant is decided when state==IDLE or done. Candidates: c_x = (pend_x & ~(completing x)) | x_early_strobe.
//    * both candidates: SERVE_D, unless streak==D_STREAK_MAX, then SERVE_I;
//    * one candidate: serve it; none: IDLE.
//  - Latency: strobe in cycle N gives mem_req in N+1. A chained grant is back-to-back with no idle cycle.
//  - streak: +1 on each D grant taken while c_i=1 (saturates at D_STREAK_MAX). Cleared on any I grant or when c_i=0.
//  - Watchdog: wdog clears on a new grant and counts each SERVE cycle without mem_ready.
//    * At wdog==TIMEOUT the access is force-completed: read data 32'h0; bus_error=1 for that cycle; bus_error_seen set.
//  - mem_ready while IDLE is ignored. mem_rdata passes to both x_read_data unregistered.
//  - x_early_strobe while x_stall=1 is a protocol violation: simulation assertion, pend stays 1, strobe dropped.
//  - Address/data are sampled live from the ports each SERVE cycle. Ports hold them stable while stalled.
// STRUCTURE
//  - Shared package/include: ARB_IDLE/ARB_SERVE_I/ARB_SERVE_D (2-bit encoding) and the force-complete read value constant.
//  - One sub-module, arb_watchdog (clear, count enable, TIMEOUT compare, expiry pulse). Arbitration stays inline.
// TESTING
//  1. Zero-wait memory (mem_ready tied 1), d_early_strobe in cycle 5, write, be=4'b0011
//     -> cycle 6: mem_req=1, mem_write=1, mem_be=4'b0011, d_stall=0.
//  2. Both strobes in cycle 5, mem_ready 2 cycles after each req
//     -> D served cycles 6-7, I served cycles 8-9; i_stall high cycles 6-8, low in 9.
//  3. D strobed every completion while I pending, D_STREAK_MAX=4 -> 4 D grants, then I granted; streak returns to 0.
//  4. mem_ready held 0, TIMEOUT=255 -> 255th cycle after grant: bus_error pulse, d_read_data=0, d_stall drops, bus_error_seen stays 1.
//  5. reset_n low mid SERVE_D with wait states -> mem_req and d_stall 0 immediately; after release, first strobe served normally.
//  6. D completes in the same cycle as a new d_early_strobe -> pend_d stays 1; next SERVE_D starts back-to-back.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared arbiter definitions: grant state encoding and the forced-completion read value.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_bus_arbiter_pkg;

  // Grant state. The encoding is visible on the bus when debugging, so it is fixed.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_SERVE_I = 2'b01,
    ARB_SERVE_D = 2'b10
  } arb_state_t;

  // Read data returned to the requester when the watchdog abandons an access.
  localparam logic [31:0] ARB_FORCE_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Access watchdog: counts wait cycles of the granted access and flags expiry at TIMEOUT.
// Latency: expired/bus_error are combinational from the registered count.
// Backpressure: none; the count holds at TIMEOUT until the arbiter clears it.
//
// Ports:
//   clock, reset_n  clock and async active-low reset
//   clear           a new grant decision is taken this cycle; restart at 0
//   count_en        an access is open on the bus
//   mem_ready       memory completed this cycle; no wait cycle to count
//   expired         count has reached TIMEOUT
//   bus_error       access is being force-completed this cycle
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  input  logic mem_ready,
  output logic expired,
  output logic bus_error
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] wdog;

  assign expired = (wdog == W'(TIMEOUT));
  // A real mem_ready at the expiry cycle wins: the access completes normally.
  assign bus_error = count_en & expired & ~mem_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog <= '0;
    end else if (clear) begin
      wdog <= '0;
    end else if (count_en && !mem_ready && !expired) begin
      wdog <= wdog + W'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch (I) and data (D) early-strobe ports with D-streak fairness.
// Latency: strobe in cycle N -> mem_req in N+1; chained grants run back-to-back with no idle cycle.
// Backpressure: x_stall holds the requester until mem_ready (or the watchdog) completes its access.
//
// Ports:
//   clock, reset_n                          clock and async active-low reset
//   i_early_strobe, i_address               fetch request; i_stall / i_read_data back to fetch
//   d_early_strobe, d_early_write, d_*      data request; d_stall / d_read_data back to data port
//   mem_req/addr/write/be/wdata             bus side, driven by the current grant
//   mem_ready, mem_rdata                    bus completion and read data
//   bus_error, bus_error_seen               watchdog expiry pulse and its sticky copy
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int D_STREAK_MAX = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_early_strobe,
  input  logic [31:0] i_address,
  output logic        i_stall,
  output logic [31:0] i_read_data,
  input  logic        d_early_strobe,
  input  logic        d_early_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_write_data,
  input  logic [3:0]  d_byte_select,
  output logic        d_stall,
  output logic [31:0] d_read_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_error,
  output logic        bus_error_seen
);

  arb_state_t  state;
  arb_state_t  next_grant;
  logic        pend_i;
  logic        pend_d;
  logic        wr_d;
  logic [3:0]  streak;
  logic        expired;
  logic        done;
  logic        done_i;
  logic        done_d;
  logic        decide;
  logic        c_i;
  logic        c_d;
  logic [31:0] rdata_bus;

  assign mem_req = (state != ARB_IDLE);
  assign done    = mem_req & (mem_ready | expired);
  assign done_i  = (state == ARB_SERVE_I) & done;
  assign done_d  = (state == ARB_SERVE_D) & done;
  assign decide  = (state == ARB_IDLE) | done;

  // A port competes if it has an access left after this cycle or strobes now;
  // including the strobe is what lets a completion chain straight into the next grant.
  assign c_i = (pend_i & ~done_i) | i_early_strobe;
  assign c_d = (pend_d & ~done_d) | d_early_strobe;

  // Combinational stall so a zero-wait access never stalls its requester.
  assign i_stall = pend_i & ~done_i;
  assign d_stall = pend_d & ~done_d;

  always_comb begin
    next_grant = ARB_IDLE;
    if (c_i && c_d) begin
      next_grant = (streak == 4'(D_STREAK_MAX)) ? ARB_SERVE_I : ARB_SERVE_D;
    end else if (c_i) begin
      next_grant = ARB_SERVE_I;
    end else if (c_d) begin
      next_grant = ARB_SERVE_D;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ARB_IDLE;
      pend_i         <= 1'b0;
      pend_d         <= 1'b0;
      wr_d           <= 1'b0;
      streak         <= 4'd0;
      bus_error_seen <= 1'b0;
    end else begin
      if (decide) begin
        state <= next_grant;
      end

      // Set wins over clear so a strobe coinciding with completion queues the next access.
      if (i_early_strobe) begin
        pend_i <= 1'b1;
      end else if (done_i) begin
        pend_i <= 1'b0;
      end
      if (d_early_strobe) begin
        pend_d <= 1'b1;
      end else if (done_d) begin
        pend_d <= 1'b0;
      end

      // A strobe during a stall is dropped, so it must not retarget the open access.
      if (d_early_strobe && !d_stall) begin
        wr_d <= d_early_write;
      end

      if (!c_i) begin
        streak <= 4'd0;
      end else if (decide && next_grant == ARB_SERVE_I) begin
        streak <= 4'd0;
      end else if (decide && next_grant == ARB_SERVE_D && streak != 4'(D_STREAK_MAX)) begin
        streak <= streak + 4'd1;
      end

      if (bus_error) begin
        bus_error_seen <= 1'b1;
      end
    end
  end

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (decide),
    .count_en  (mem_req),
    .mem_ready (mem_ready),
    .expired   (expired),
    .bus_error (bus_error)
  );

  always_comb begin
    mem_addr = 32'h0;
    case (state)
      ARB_SERVE_I: mem_addr = i_address;
      ARB_SERVE_D: mem_addr = d_address;
      default:     mem_addr = 32'h0;
    endcase
  end

  assign mem_write = (state == ARB_SERVE_D) & wr_d;
  assign mem_be    = mem_write ? d_byte_select : 4'b0000;
  assign mem_wdata = (state == ARB_SERVE_D) ? d_write_data : 32'h0;

  // Read data is only meaningful on the completing cycle; keep it quiet when idle.
  assign rdata_bus   = !mem_req ? 32'h0 : (bus_error ? ARB_FORCE_RDATA : mem_rdata);
  assign i_read_data = rdata_bus;
  assign d_read_data = rdata_bus;

  a_i_strobe_while_stalled: assert property (@(posedge clock) disable iff (!reset_n)
    !(i_early_strobe && i_stall));
  a_d_strobe_while_stalled: assert property (@(posedge clock) disable iff (!reset_n)
    !(d_early_strobe && d_stall));

endmodule
